// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end: FSM encoding, PC step and reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target: word-aligned branch PC + 4 + sign-extended word offset, wrapping silently.
module branch_target_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [15:0]       branch_imm,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] offset;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^branch_pc[1:0];
  assign base           = {branch_pc[ADDR_W-1:2], 2'b00};
  assign offset         = {{(ADDR_W-16){branch_imm[15]}}, branch_imm} << 2;
  assign target         = base + ADDR_W'(PC_INC) + offset;

endmodule

// File: rtl/pc_fetch_redirect.sv
// PC / instruction-fetch controller with branch redirect and wrong-path flush.
// Optional FETCH_STATS_EN adds saturating fetch_count / flush_count outputs.
module pc_fetch_redirect
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_branch,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [15:0]       branch_imm,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              flush,
  output fetch_state_e      dbg_state
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  // imem handshake: a request completes in the cycle where imem_req && imem_ack;
  // once raised, imem_req and imem_addr stay put until that cycle (only reset cancels).
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;
  logic              req_c;
  logic [ADDR_W-1:0] target;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_target (
    .branch_pc  (branch_pc),
    .branch_imm (branch_imm),
    .target     (target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    req_c      = 1'b0;

    case (state_q)
      FETCH:       req_c = ~valid_q | ~stall;
      WAIT, DRAIN: req_c = 1'b1;
      default:     req_c = 1'b0;
    endcase

    if (take_branch) begin
      flush_d = 1'b1;
      valid_d = 1'b0;
      // An in-flight request cannot be withdrawn, so its data is drained later.
      if (req_c && !imem_ack) begin
        state_d = DRAIN;
        tgt_d   = target;
      end else begin
        state_d = FETCH;
        pc_d    = target;
      end
    end else if (req_c && imem_ack) begin
      state_d = FETCH;
      if (state_q == DRAIN) begin
        pc_d = tgt_q;
        if (!stall) valid_d = 1'b0;
      end else begin
        instr_d    = imem_rdata;
        instr_pc_d = pc_q;
        valid_d    = 1'b1;
        pc_d       = pc_q + ADDR_W'(PC_INC);
      end
    end else begin
      if (req_c && state_q == FETCH) state_d = WAIT;
      else if (!req_c)               state_d = FETCH;
      if (!stall) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
    end
  end

  assign imem_req    = req_c & ~reset;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign flush       = flush_q;
  assign dbg_state   = state_q;

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_c;

  always_comb begin
    load_c      = req_c & imem_ack & ~take_branch & (state_q != DRAIN);
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_c && fetch_cnt_q != 16'hFFFF)  fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (flush_d && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule
